sync_fifo_param: RTL

//  Parametrised single-clock FIFO with run-time-free mode select: standard (registered

---
 rtl/sync_fifo_param_if.sv | 36 +++
 rtl/sync_fifo_param.sv | 100 ++++++++++
 2 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - handshake/status bundle for sync_fifo_param
// Purpose: groups the FIFO write/read handshake, data and status signals.
// Signals:
//   din, wr_en, rd_en               producer/consumer requests (master drives)
//   dout                            read data (FIFO drives)
//   full, empty                     occupancy limits
//   almost_full, almost_empty       programmable threshold flags
//   data_count                      words written and not yet read
//   overflow, underflow             1-cycle pulses for rejected requests
// Modports: master = FIFO user, slave = FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  logic [DATA_W-1:0]        din;
  logic                     wr_en;
  logic                     rd_en;
  logic [DATA_W-1:0]        dout;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   data_count;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, almost_full, almost_empty, data_count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, almost_full, almost_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO, standard or FWFT read
// Purpose: single-clock FIFO with registered flags, occupancy count and
//          overflow/underflow pulses. FWFT=0 registers dout one cycle after an
//          accepted read; FWFT=1 presents the head word combinationally.
// Ports:
//   clk   in  single clock, all logic on posedge
//   rst   in  asynchronous active-high reset
//   bus   slave modport of sync_fifo_param_if (din/wr_en/rd_en in,
//         dout/full/empty/almost_full/almost_empty/data_count/overflow/underflow out)
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_param_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [AW:0]       w_count_nxt;
  logic [AW-1:0]     w_wr_addr;
  logic [AW-1:0]     w_rd_addr;

  // Acceptance uses the registered flags, so a pop in the same cycle never
  // frees room for a write that arrived while full (and vice versa when empty).
  assign w_wr_ok     = bus.wr_en && !r_full;
  assign w_rd_ok     = bus.rd_en && !r_empty;
  assign w_count_nxt = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
  assign w_wr_addr   = r_wr_ptr[AW-1:0];
  assign w_rd_addr   = r_rd_ptr[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + CW'(1);
      r_count        <= w_count_nxt;
      // Flags follow the next count so they change on the same edge as data_count.
      r_full         <= (w_count_nxt == CW'(DEPTH));
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= CW'(AFULL_TH));
      r_almost_empty <= (w_count_nxt <= CW'(AEMPTY_TH));
      r_overflow     <= bus.wr_en && r_full;
      r_underflow    <= bus.rd_en && r_empty;
    end
  end

  // Storage is deliberately not reset; the pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_wr_addr] <= bus.din;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_dout <= '0;
        else if (w_rd_ok) r_dout <= r_mem[w_rd_addr];
      end
      assign bus.dout = r_dout;
    end else begin : g_fwft
      // Head word is visible directly; meaningless while empty.
      assign bus.dout = r_mem[w_rd_addr];
    end
  endgenerate

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.data_count   = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
